// File: rtl/piso_tx_if.sv
// Handshake and serial-line bundle for piso_tx.
// The master drives words and the shift enable. The slave, which is piso_tx, drives the serial outputs.
interface piso_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] D;
   logic             LOAD;
   logic             READY;
   logic             EN;
   logic             Q;
   logic             OE;
   logic             WORD_START;
   logic             UNDERRUN;

   modport master (
      output D, LOAD, EN,
      input  READY, Q, OE, WORD_START, UNDERRUN
   );

   modport slave (
      input  D, LOAD, EN,
      output READY, Q, OE, WORD_START, UNDERRUN
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter that sends each word MSB-first and buffers one word.
// Define PISO_TX_IDLE_PATTERN_EN to send IDLE_PATTERN training words instead of an idle low line.
module piso_tx #(
   parameter int         WIDTH        = 4,
   parameter logic [9:0] IDLE_PATTERN = 10'h2AA
) (
   input logic    CLK_IN,
   input logic    RST_N,
   piso_tx_if.slave bus
);

   localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_IDLE_PATTERN_EN
   typedef enum logic [1:0] {IDLE_Z = 2'd0, TRAIN = 2'd1, DATA = 2'd2} state_t;
   localparam logic [WIDTH-1:0] PATTERN = IDLE_PATTERN[WIDTH-1:0];
`else
   typedef enum logic [1:0] {IDLE_Z = 2'd0, DATA = 2'd2} state_t;
   logic unused_pattern;
   assign unused_pattern = ^IDLE_PATTERN;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shr, shr_nxt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             hv, hv_nxt;
   logic             underrun_q, underrun_nxt;
   logic             ready_int;
   logic             xfer;
   logic             boundary;

   assign ready_int = !hv && RST_N;
   assign xfer      = bus.LOAD && ready_int;
   // An empty shifter counts as a boundary every cycle, so an idle line reloads at once.
   assign boundary  = bus.EN && ((state == IDLE_Z) || (cnt == LAST));

   always_ff @(posedge CLK_IN) begin
      if (!RST_N) begin
         state      <= IDLE_Z;
         shr        <= '0;
         hold       <= '0;
         cnt        <= '0;
         hv         <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         shr        <= shr_nxt;
         hold       <= hold_nxt;
         cnt        <= cnt_nxt;
         hv         <= hv_nxt;
         underrun_q <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      shr_nxt      = shr;
      hold_nxt     = hold;
      cnt_nxt      = cnt;
      hv_nxt       = hv;
      underrun_nxt = 1'b0;
      if (boundary) begin
         cnt_nxt = '0;
         if (hv) begin
            shr_nxt   = hold;
            hv_nxt    = 1'b0;
            state_nxt = DATA;
         end else if (xfer) begin
            shr_nxt   = bus.D;
            state_nxt = DATA;
         end else begin
`ifdef PISO_TX_IDLE_PATTERN_EN
            shr_nxt   = PATTERN;
            state_nxt = TRAIN;
`else
            shr_nxt   = '0;
            state_nxt = IDLE_Z;
`endif
            underrun_nxt = (state == DATA);
         end
      end else begin
         if (bus.EN) begin
            shr_nxt = {shr[WIDTH-2:0], 1'b0};
            cnt_nxt = cnt + 1'b1;
         end
         if (xfer) begin
            hold_nxt = bus.D;
            hv_nxt   = 1'b1;
         end
      end
   end

   // Outputs are gated by RST_N so the line goes quiet as soon as reset is asserted.
   assign bus.READY      = ready_int;
   assign bus.Q          = RST_N && shr[WIDTH-1];
   assign bus.OE         = RST_N && (state == DATA);
   assign bus.WORD_START = RST_N && (state != IDLE_Z) && (cnt == '0);
   assign bus.UNDERRUN   = RST_N && underrun_q;

endmodule
